// File: rtl/ifu_pkg.sv
// Shared definitions for the P7 instruction fetch unit.
// IF/ID bundle layout, reset/handler addresses and fetch bounds.
package ifu_pkg;

   localparam logic [31:0] PC_RESET_DEF   = 32'h0000_3000;
   localparam logic [31:0] PC_HANDLER_DEF = 32'h0000_4180;

   localparam logic [31:0] IM_LO = 32'h0000_3000;
   localparam logic [31:0] IM_HI = 32'h0000_4FFC;

   localparam logic [4:0]  EXC_ADEL = 5'd4;
   localparam logic [31:0] NOP      = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc8;
      logic        valid;
      logic        bd;
      logic        exc;
      logic [4:0]  exccode;
   } if_id_t;

   localparam if_id_t IFID_CLEAR = '0;

   function automatic logic adel_fault(input logic [31:0] pc);
      return (pc[1:0] != 2'b00) || (pc < IM_LO) || (pc > IM_HI);
   endfunction

endpackage

// File: rtl/ifu_ifid_reg.sv
// IF/ID pipeline register with synchronous clear, flush, load and hold.
// A flushed slot carries the all-zero nop bundle.
module ifid_reg
   import ifu_pkg::*;
(
   input  logic   clk,
   input  logic   reset,
   input  logic   flush,
   input  logic   load,
   input  if_id_t d,
   output if_id_t q
);

   // clear on reset/flush, otherwise load or hold
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         q <= IFID_CLEAR;
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: PC register, next-PC priority mux, IF/ID.
// Optional fetch address check enabled by defining IFU_ADEL_CHECK_EN.
module ifu
   import ifu_pkg::*;
#(
   parameter logic [31:0] PC_RESET   = PC_RESET_DEF,
   parameter logic [31:0] PC_HANDLER = PC_HANDLER_DEF
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        exc_req,
   input  logic        eret_req,
   input  logic [31:0] epc,
   output logic [31:0] pc_out,
   input  logic [31:0] instr_in,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc8,
   output logic        id_valid,
   output logic        id_bd,
   output logic        id_exc,
   output logic [4:0]  id_exccode
);

   logic [31:0] pc;
   logic [31:0] pc_next;
   logic        flush;
   logic        load;
   if_id_t      slot;
   if_id_t      ifid;

   assign flush = exc_req | eret_req;
   assign load  = ~stall;

   // next PC by priority: exception, eret, stall, redirect, sequential
   always_comb begin
      pc_next = pc + 32'd4;
      if (exc_req) begin
         pc_next = PC_HANDLER;
      end else if (eret_req) begin
         pc_next = epc;
      end else if (stall) begin
         pc_next = pc;
      end else if (redirect) begin
         pc_next = redirect_pc;
      end
   end

   // PC register; drives the fetch address directly
   always_ff @(posedge clk) begin
      if (reset) begin
         pc <= PC_RESET;
      end else begin
         pc <= pc_next;
      end
   end

   // bundle for the fetch in flight; a redirect marks it as delay slot
   always_comb begin
      slot         = IFID_CLEAR;
      slot.pc      = pc;
      slot.pc8     = pc + 32'd8;
      slot.valid   = 1'b1;
      slot.bd      = redirect;
`ifdef IFU_ADEL_CHECK_EN
      if (adel_fault(pc)) begin
         slot.instr   = NOP;
         slot.exc     = 1'b1;
         slot.exccode = EXC_ADEL;
      end else begin
         slot.instr   = instr_in;
      end
`else
      slot.instr   = instr_in;
`endif
   end

   ifid_reg u_ifid (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .load  (load),
      .d     (slot),
      .q     (ifid)
   );

   assign pc_out     = pc;
   assign id_instr   = ifid.instr;
   assign id_pc      = ifid.pc;
   assign id_pc8     = ifid.pc8;
   assign id_valid   = ifid.valid;
   assign id_bd      = ifid.bd;
   assign id_exc     = ifid.exc;
   assign id_exccode = ifid.exccode;

endmodule

// File: tb/tb_ifu.sv
// Directed scoreboard bench for the instruction fetch unit.
// Expected fetch state is queued per step and checked after the edge.
module tb_ifu;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        exc_req;
   logic        eret_req;
   logic [31:0] epc;
   logic [31:0] pc_out;
   logic [31:0] instr_in;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic [31:0] id_pc8;
   logic        id_valid;
   logic        id_bd;
   logic        id_exc;
   logic [4:0]  id_exccode;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] ipc;
      logic [31:0] ipc8;
      logic        valid;
      logic        bd;
      logic        exc;
      logic [4:0]  code;
   } exp_t;

   exp_t sb[$];
   int   n_cmp;
   int   n_bad;

   function automatic logic [31:0] imem(input logic [31:0] a);
      return {~a[15:0], a[15:0]} ^ 32'h1234_0000;
   endfunction

   function automatic logic fault(input logic [31:0] a);
`ifdef IFU_ADEL_CHECK_EN
      return (a[1:0] != 2'b00) || (a < 32'h3000) || (a > 32'h4FFC);
`else
      return 1'b0;
`endif
   endfunction

   assign instr_in = imem(pc_out);

   ifu dut (
      .clk         (clk),
      .reset       (reset),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .exc_req     (exc_req),
      .eret_req    (eret_req),
      .epc         (epc),
      .pc_out      (pc_out),
      .instr_in    (instr_in),
      .id_instr    (id_instr),
      .id_pc       (id_pc),
      .id_pc8      (id_pc8),
      .id_valid    (id_valid),
      .id_bd       (id_bd),
      .id_exc      (id_exc),
      .id_exccode  (id_exccode)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk32(input string tag, input logic [31:0] got,
                        input logic [31:0] want);
      n_cmp++;
      assert (got === want) else begin
         n_bad++;
         $error("FAIL %s got=%h want=%h", tag, got, want);
      end
   endtask

   task automatic step(input string tag,
                       input logic rs, input logic st,
                       input logic rd, input logic [31:0] rpc,
                       input logic ex, input logic er,
                       input logic [31:0] ep,
                       input logic [31:0] e_pc, input logic [31:0] e_ipc,
                       input logic e_valid, input logic e_bd);
      exp_t e;
      exp_t g;
      logic flt;
      reset       = rs;
      stall       = st;
      redirect    = rd;
      redirect_pc = rpc;
      exc_req     = ex;
      eret_req    = er;
      epc         = ep;
      flt     = e_valid && fault(e_ipc);
      e.pc    = e_pc;
      e.valid = e_valid;
      e.ipc   = e_valid ? e_ipc : 32'h0;
      e.ipc8  = e_valid ? e_ipc + 32'd8 : 32'h0;
      e.instr = (e_valid && !flt) ? imem(e_ipc) : 32'h0;
      e.bd    = e_valid ? e_bd : 1'b0;
      e.exc   = flt;
      e.code  = flt ? 5'd4 : 5'd0;
      sb.push_back(e);
      @(posedge clk);
      #1;
      n_cmp++;
      assert (sb.size() != 0) else begin
         n_bad++;
         $error("FAIL %s scoreboard empty got=0 want=1", tag);
      end
      if (sb.size() != 0) begin
         g = sb.pop_front();
         chk32({tag, ".pc_out"},   pc_out,             g.pc);
         chk32({tag, ".id_pc"},    id_pc,              g.ipc);
         chk32({tag, ".id_pc8"},   id_pc8,             g.ipc8);
         chk32({tag, ".id_instr"}, id_instr,           g.instr);
         chk32({tag, ".id_valid"}, {31'd0, id_valid},  {31'd0, g.valid});
         chk32({tag, ".id_bd"},    {31'd0, id_bd},     {31'd0, g.bd});
         chk32({tag, ".id_exc"},   {31'd0, id_exc},    {31'd0, g.exc});
         chk32({tag, ".id_code"},  {27'd0, id_exccode}, {27'd0, g.code});
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      reset = 1'b1;
      stall = 1'b0;
      redirect = 1'b0;
      redirect_pc = 32'h0;
      exc_req = 1'b0;
      eret_req = 1'b0;
      epc = 32'h0;

      // tag rst st rd rpc ex er epc | pc idpc valid bd
      step("rst",   1,0,0,32'h0,   0,0,32'h0, 32'h3000,32'h0,   0,0);
      step("seq0",  0,0,0,32'h0,   0,0,32'h0, 32'h3004,32'h3000,1,0);
      step("seq1",  0,0,0,32'h0,   0,0,32'h0, 32'h3008,32'h3004,1,0);
      step("seq2",  0,0,0,32'h0,   0,0,32'h0, 32'h300C,32'h3008,1,0);
      step("seq3",  0,0,0,32'h0,   0,0,32'h0, 32'h3010,32'h300C,1,0);
      step("br",    0,0,1,32'h3100,0,0,32'h0, 32'h3100,32'h3010,1,1);
      step("tgt",   0,0,0,32'h0,   0,0,32'h0, 32'h3104,32'h3100,1,0);
      step("br2",   0,0,1,32'h3020,0,0,32'h0, 32'h3020,32'h3104,1,1);
      step("stl0",  0,1,1,32'h3200,0,0,32'h0, 32'h3020,32'h3104,1,1);
      step("stl1",  0,1,1,32'h3200,0,0,32'h0, 32'h3020,32'h3104,1,1);
      step("stl2",  0,1,1,32'h3200,0,0,32'h0, 32'h3020,32'h3104,1,1);
      step("stlbr", 0,0,1,32'h3200,0,0,32'h0, 32'h3200,32'h3020,1,1);
      step("tgt2",  0,0,0,32'h0,   0,0,32'h0, 32'h3204,32'h3200,1,0);
      step("br3",   0,0,1,32'h3040,0,0,32'h0, 32'h3040,32'h3204,1,1);
      step("exc",   0,1,1,32'h3300,1,0,32'h0, 32'h4180,32'h0,   0,0);
      step("hdl",   0,0,0,32'h0,   0,0,32'h0, 32'h4184,32'h4180,1,0);
      step("eret",  0,0,0,32'h0,   0,1,32'h3044,32'h3044,32'h0, 0,0);
      step("epc",   0,0,0,32'h0,   0,0,32'h0, 32'h3048,32'h3044,1,0);
      step("excer", 0,0,0,32'h0,   1,1,32'h3044,32'h4180,32'h0, 0,0);
      step("hdl2",  0,0,0,32'h0,   0,0,32'h0, 32'h4184,32'h4180,1,0);
      step("stlrs", 0,1,0,32'h0,   0,0,32'h0, 32'h4184,32'h4180,1,0);
      step("rstmid",1,1,1,32'h3500,0,0,32'h0, 32'h3000,32'h0,   0,0);
      step("rel",   0,0,0,32'h0,   0,0,32'h0, 32'h3004,32'h3000,1,0);
      step("brmis", 0,0,1,32'h3002,0,0,32'h0, 32'h3002,32'h3004,1,1);
      step("mis",   0,0,0,32'h0,   0,0,32'h0, 32'h3006,32'h3002,1,0);
      step("brtop", 0,0,1,32'hFFFF_FFFC,0,0,32'h0,
           32'hFFFF_FFFC,32'h3006,1,1);
      step("wrap",  0,0,0,32'h0,   0,0,32'h0, 32'h0,   32'hFFFF_FFFC,1,0);
      step("zero",  0,0,0,32'h0,   0,0,32'h0, 32'h4,   32'h0,   1,0);
      step("brhi",  0,0,1,32'h4FFC,0,0,32'h0, 32'h4FFC,32'h4,   1,1);
      step("hi",    0,0,0,32'h0,   0,0,32'h0, 32'h5000,32'h4FFC,1,0);
      step("past",  0,0,0,32'h0,   0,0,32'h0, 32'h5004,32'h5000,1,0);

      n_cmp++;
      assert (sb.size() == 0) else begin
         n_bad++;
         $error("FAIL sb_drain got=%0d want=0", sb.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ifu.md
# ifu

Instruction fetch unit for the P7 pipelined MIPS core. It owns the program counter and drives the fetch address into the instruction memory. It takes the instruction word back in the same cycle and registers it, with its PC and flags, into the IF/ID pipeline register. It resolves stall, branch/jump redirect, exception entry and `eret` return with fixed priority.

## Interface
Parameters:
- `PC_RESET`, `32'h0000_3000`: PC after reset.
- `PC_HANDLER`, `32'h0000_4180`: exception entry address.

Ports:
- `clk`: input, 1 bit. Rising-edge clock.
- `reset`: input, 1 bit. Synchronous, active-high.
- `stall`: input, 1 bit. Hazard stall from the hazard unit. Holds PC and IF/ID.
- `redirect`: input, 1 bit. Branch taken or jump, resolved in ID.
- `redirect_pc`: input, 32 bits. Target for `redirect`.
- `exc_req`: input, 1 bit. CP0 exception/interrupt taken this cycle.
- `eret_req`: input, 1 bit. `eret` committing this cycle.
- `epc`: input, 32 bits. Return address from CP0.
- `pc_out`: output, 32 bits. Fetch address to instruction memory.
- `instr_in`: input, 32 bits. Instruction word from instruction memory, combinational on `pc_out`.
- `id_instr`: output, 32 bits. IF/ID instruction.
- `id_pc`: output, 32 bits. IF/ID PC.
- `id_pc8`: output, 32 bits. IF/ID PC+8, the link value.
- `id_valid`: output, 1 bit. IF/ID holds a real instruction.
- `id_bd`: output, 1 bit. IF/ID instruction is a branch delay slot.
- `id_exc`: output, 1 bit. Fetch fault flag (see Configuration).
- `id_exccode`: output, 5 bits. Fetch fault code.

## Operation
- `pc_out` is the PC register itself; there is no combinational path from any input to `pc_out`.
- Each rising edge applies exactly one action, chosen by this priority:
  1. `reset`:
     - PC <= `PC_RESET`.
     - IF/ID cleared: `id_instr`=0, `id_pc`=0, `id_pc8`=0, `id_valid`=0, `id_bd`=0, `id_exc`=0, `id_exccode`=0.
  2. `exc_req`:
     - PC <= `PC_HANDLER`.
     - IF/ID flushed to the reset values.
     - Overrides `stall`.
  3. `eret_req`:
     - PC <= `epc`.
     - IF/ID flushed.
     - Overrides `stall`. `eret` has no delay slot.
  4. `stall`:
     - PC and every IF/ID field hold.
     - `redirect` is ignored; ID holds the branch and re-presents `redirect` after the stall clears.
  5. `redirect`:
     - PC <= `redirect_pc`.
     - IF/ID loads the current fetch (the delay slot) with `id_valid`=1 and `id_bd`=1.
  6. Default:
     - PC <= PC+4.
     - IF/ID loads `id_instr`=`instr_in`, `id_pc`=PC, `id_pc8`=PC+8, `id_valid`=1, `id_bd`=0.
- Arithmetic:
  - 32-bit unsigned; PC+4 and PC+8 wrap modulo 2^32.
  - `redirect_pc` and `epc` are loaded unmodified, with no alignment masking.
- A flushed slot has `id_instr`=0 (sll $0 nop), so downstream decode needs no special case.

## Timing
- Fetch latency: the instruction at `pc_out` appears on `id_instr` one cycle later.
- Redirect penalty: zero bubbles. The delay slot executes, and the target is fetched on the cycle after `redirect` is sampled.
- Exception/`eret` penalty: one bubble (the flushed IF/ID slot). The handler or EPC instruction reaches ID two cycles after the request.
- Simultaneous events:
  - `exc_req` with `eret_req`: the exception wins.
  - `stall` with `exc_req`: the exception wins.
  - `redirect` with `exc_req`: the redirect is dropped.
- Reset asserted mid-stall or mid-redirect: PC = `PC_RESET` on the next edge, and all outputs are at reset values.

## Configuration
- With `IFU_ADEL_CHECK_EN` defined, the current PC is checked at each IF/ID load.
  - Fault condition: PC[1:0]≠0, or PC outside `32'h0000_3000`–`32'h0000_4FFC`.
  - On a fault, IF/ID loads `id_instr`=0, `id_exc`=1, `id_exccode`=5'd4 (AdEL), with `id_pc` = the faulting PC and `id_valid`=1.
  - PC still advances normally; CP0 raises `exc_req` when the slot commits.
- Without the macro, `id_exc` and `id_exccode` are constant 0 and there is no range logic.

## Structure
- Shared package holds:
  - `PC_RESET` and `PC_HANDLER` defaults.
  - Legal fetch bounds `IM_LO`=`32'h0000_3000` and `IM_HI`=`32'h0000_4FFC`.
  - `EXC_ADEL`=5'd4.
  - The NOP constant 0.
- One sub-module, `ifid_reg`, is natural: the IF/ID register with load/hold/flush controls. `ifu` keeps the PC register, next-PC mux and priority logic.

## Test plan
- Reset, then release with no other inputs → `pc_out` = 3000, 3004, 3008. `id_pc` trails `pc_out` by one cycle; `id_pc8` = `id_pc`+8; `id_valid`=1 from the second edge.
- At PC=3010, `redirect`=1 with `redirect_pc`=3100 → next `pc_out`=3100. IF/ID holds the instruction at 3010 with `id_bd`=1, then the instruction at 3100 with `id_bd`=0.
- `stall`=1 for 3 cycles at PC=3020 while `redirect`=1 → PC and IF/ID frozen for 3 cycles. Redirect takes effect on the first unstalled edge.
- `exc_req`=1 with `stall`=1 and `redirect`=1 at PC=3040 → `pc_out`=4180, `id_valid`=0, `id_instr`=0. The handler word reaches `id_instr` one cycle later.
- `eret_req`=1 with `epc`=3044 → `pc_out`=3044 and IF/ID flushed. `exc_req` and `eret_req` together → `pc_out`=4180.
- With `IFU_ADEL_CHECK_EN` defined, `redirect_pc`=3002 → `id_exc`=1, `id_exccode`=4, `id_instr`=0, `id_pc`=3002. Without the macro, `id_exc` stays 0.
